t_flipflop: RTL and testbench



---
 rtl/t_flipflop_pkg.sv | 7 +
 rtl/t_flipflop.sv | 27 ++
 tb/tb_t_flipflop.sv | 136 +++++++++++++
 3 files changed

// File: rtl/t_flipflop_pkg.sv
// t_flipflop_pkg: shared definitions for the toggle flip-flop primitive.
//   TFF_DEFAULT_WIDTH : default bit count (classic single T flip-flop)
package t_flipflop_pkg;

  localparam int unsigned TFF_DEFAULT_WIDTH = 1;

endpackage : t_flipflop_pkg

// File: rtl/t_flipflop.sv
// t_flipflop: WIDTH independent synchronous toggle flip-flops.
// Each bit of Q inverts on a rising clk edge when its T bit is high and holds
// otherwise. A synchronous active-high reset loads RST_VAL and overrides T.
// Ports (positional order is relied on by existing instantiations):
//   T     : per-bit toggle enable, sampled on rising clk
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   Q     : registered state, driven straight from flops
module t_flipflop
  import t_flipflop_pkg::*;
#(
  parameter int unsigned       WIDTH   = TFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic [WIDTH-1:0] T,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Q
);

  // XOR with T is the per-bit toggle enable; Q has no combinational path.
  always_ff @(posedge clk) begin
    if (reset) Q <= RST_VAL;
    else       Q <= Q ^ T;
  end

endmodule : t_flipflop

// File: tb/tb_t_flipflop.sv
module tb_t_flipflop;

  logic       clk = 1'b0;
  logic       reset, reset4;
  logic       t1;
  logic [3:0] t4;
  logic       q1;
  logic [3:0] q4;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected value pushed when stimulus is driven, popped after edge
  logic [3:0] sb [$];

  typedef struct {
    logic  rst;
    logic  t;
    logic  q;
    string name;
  } vec_t;

  vec_t vecs [18];

  always #5 clk = ~clk;

  t_flipflop dut1 (
    .T(t1), .clk(clk), .reset(reset), .Q(q1)
  );

  t_flipflop #(.WIDTH(4), .RST_VAL(4'b1010)) dut4 (
    .T(t4), .clk(clk), .reset(reset4), .Q(q4)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // drive at negedge, push expectation, compare #1 after the next rising edge
  task automatic step4(input logic r, input logic [3:0] t, input logic [3:0] exp,
                       input string name);
    logic [3:0] e;
    reset4 = r;
    t4     = t;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, q4, e);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] model;
    logic [3:0] rt;
    logic [3:0] e;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, "reset_edge5"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, "reset_hold15"};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, "tog25"};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, "tog35"};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, "tog45"};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, "tog55"};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, "hold65"};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, "hold75"};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, "res85"};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, "res95"};
    vecs[10] = '{1'b0, 1'b1, 1'b1, "res105"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, "res115"};
    vecs[12] = '{1'b0, 1'b1, 1'b1, "res125"};
    vecs[13] = '{1'b1, 1'b1, 1'b0, "rst_during_toggle"};
    vecs[14] = '{1'b0, 1'b1, 1'b1, "first_after_rst"};
    vecs[15] = '{1'b0, 1'b1, 1'b0, "div2_a"};
    vecs[16] = '{1'b0, 1'b0, 1'b0, "hold_b"};
    vecs[17] = '{1'b0, 1'b1, 1'b1, "div2_c"};

    reset4 = 1'b1;
    t4     = 4'b0000;

    // table: inputs applied at t=0,10,20,... (clk low), checked at 6,16,26,...
    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst;
      t1    = vecs[i].t;
      sb.push_back({3'b000, vecs[i].q});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: scoreboard empty", vecs[i].name);
      end else begin
        e = sb.pop_front();
        check(vecs[i].name, {3'b000, q1}, e);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    t1    = 1'b0;

    // width-4, non-zero reset value
    step4(1'b1, 4'b0000, 4'b1010, "w4_reset");
    step4(1'b0, 4'b0011, 4'b1001, "w4_t0011");

    // random toggles against a reference model
    model = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      rt    = 4'($urandom_range(0, 15));
      model = model ^ rt;
      step4(1'b0, rt, model, $sformatf("w4_rand%0d", i));
    end

    // reset wins over toggle-all, then toggling resumes from RST_VAL
    step4(1'b1, 4'b1111, 4'b1010, "w4_rst_over_tog");
    step4(1'b0, 4'b1111, 4'b0101, "w4_after_rst");
    step4(1'b0, 4'b0000, 4'b0101, "w4_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute bound so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_t_flipflop
